// File: rtl/pc_pkg.sv
// Shared decode constants, default addresses and next-PC source encoding
// for the program-counter unit.
package pc_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_ERET = 6'b010000;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;
    localparam logic [5:0] FN_SYSCALL = 6'b001100;

    localparam logic [4:0] REG_RA = 5'd31;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;

    typedef enum logic [2:0] {
        SRC_SEQ,
        SRC_BR,
        SRC_JIMM,
        SRC_JREG,
        SRC_EXC,
        SRC_ERET
    } pc_src_e;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer with an occupancy count. A push
// into a full stack overwrites the oldest entry; a pop from an empty
// stack is ignored.
module pc_ras
    import pc_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] top_o,
    output logic             valid_o
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]    ptr_q;
    logic [CW-1:0]    cnt_q;
    logic [PW-1:0]    top_idx;

    // ptr_q is the next write slot; when full it also points at the oldest entry
    assign top_idx = ptr_q - PW'(1);
    assign valid_o = (cnt_q != '0);
    assign top_o   = valid_o ? mem_q[top_idx] : '0;

    // Stack update; push and pop are never requested together by the decoder
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (en_i) begin
            if (push_i) begin
                mem_q[ptr_q] <= data_i;
                ptr_q        <= ptr_q + PW'(1);
                if (cnt_q != CW'(RAS_DEPTH)) begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else if (pop_i && valid_o) begin
                ptr_q <= top_idx;
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/pc_ctrl.sv
// Registered program counter: next-PC priority mux, EPC / exception level,
// redirect flag and a return-address stack predicting JR $31 targets.
module pc_ctrl
    import pc_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(DEF_RESET_PC),
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(DEF_EXC_VEC),
    parameter int               RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             branch_i,
    input  logic             jump_i,
    input  logic [31:0]      ins_i,
    input  logic [WIDTH-1:0] jreg_i,
    input  logic             irq_i,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] link_addr_o,
    output logic [WIDTH-1:0] epc_o,
    output logic             exl_o,
    output logic             redirect_o,
    output logic [WIDTH-1:0] ras_pred_o,
    output logic             ras_valid_o
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             exl_q, exl_d;
    logic             redirect_q, redirect_d;

    logic [5:0] op, fn;
    logic [4:0] rs;
    logic       is_r, is_j, is_jal, is_eret, is_jr, is_jalr, is_syscall;

    logic [WIDTH-1:0] pc_seq, pc_br, pc_jimm, br_off, link;
    pc_src_e          src;
    logic             ras_push, ras_pop;

    assign op = ins_i[31:26];
    assign fn = ins_i[5:0];
    assign rs = ins_i[25:21];

    assign is_r       = (op == OP_R);
    assign is_j       = (op == OP_J);
    assign is_jal     = (op == OP_JAL);
    assign is_eret    = (op == OP_ERET);
    assign is_jr      = is_r && (fn == FN_JR);
    assign is_jalr    = is_r && (fn == FN_JALR);
    assign is_syscall = is_r && (fn == FN_SYSCALL);

    assign pc_seq  = pc_q + WIDTH'(4);
    assign link    = pc_q + WIDTH'(8);
    assign br_off  = {{(WIDTH-18){ins_i[15]}}, ins_i[15:0], 2'b00};
    assign pc_br   = pc_seq + br_off;
    assign pc_jimm = {pc_q[WIDTH-1:28], ins_i[25:0], 2'b00};

    // Select the next-PC source; traps first, then ERET, branch, jumps
    always_comb begin
        src = SRC_SEQ;
        if ((irq_i && !exl_q) || (jump_i && is_syscall)) begin
            src = SRC_EXC;
        end else if (jump_i && is_eret) begin
            src = SRC_ERET;
        end else if (branch_i) begin
            src = SRC_BR;
        end else if (jump_i && (is_j || is_jal)) begin
            src = SRC_JIMM;
        end else if (jump_i && (is_jr || is_jalr)) begin
            src = SRC_JREG;
        end
    end

    // Compute next PC / EPC / EXL from the selected source
    always_comb begin
        pc_d  = pc_seq;
        epc_d = epc_q;
        exl_d = exl_q;
        case (src)
            SRC_EXC: begin
                epc_d = pc_q;
                exl_d = 1'b1;
                pc_d  = EXC_VEC;
            end
            SRC_ERET: begin
                pc_d  = epc_q;
                exl_d = 1'b0;
            end
            SRC_BR:   pc_d = pc_br;
            SRC_JIMM: pc_d = pc_jimm;
            SRC_JREG: pc_d = jreg_i;
            default:  pc_d = pc_seq;
        endcase
    end

    // JALR only pushes, even with rs=31; traps and ERET never touch the stack
    assign ras_push   = ((src == SRC_JIMM) && is_jal) || ((src == SRC_JREG) && is_jalr);
    assign ras_pop    = (src == SRC_JREG) && is_jr && (rs == REG_RA);
    assign redirect_d = (src != SRC_SEQ);

    // Architectural state; a stall freezes everything including redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            epc_q      <= '0;
            exl_q      <= 1'b0;
            redirect_q <= 1'b0;
        end else if (!stall_i) begin
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            exl_q      <= exl_d;
            redirect_q <= redirect_d;
        end
    end

    pc_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (~stall_i),
        .push_i  (ras_push),
        .pop_i   (ras_pop),
        .data_i  (link),
        .top_o   (ras_pred_o),
        .valid_o (ras_valid_o)
    );

    assign pc_o        = pc_q;
    assign link_addr_o = link;
    assign epc_o       = epc_q;
    assign exl_o       = exl_q;
    assign redirect_o  = redirect_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl: a behavioural model pushes the expected post-edge
// state into a scoreboard queue as each cycle is driven; each test task
// pops and compares against the sampled DUT outputs.
module tb_pc_ctrl;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] link;
        logic [31:0] epc;
        logic [31:0] pred;
        logic        exl;
        logic        redir;
        logic        valid;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, branch = 1'b0, jump = 1'b0, irq = 1'b0;
    logic [31:0] ins = '0, jreg = '0;
    logic [31:0] pc, link_addr, epc, ras_pred;
    logic        exl, redirect, ras_valid;

    int checks = 0;
    int errors = 0;

    obs_t sb[$];

    logic [31:0] m_pc, m_epc;
    logic        m_exl, m_redir;
    logic [31:0] m_ras[$];

    localparam logic [31:0] I_NOP  = 32'h0000_0000;
    localparam logic [31:0] I_JR31 = 32'h03E0_0008;
    localparam logic [31:0] I_JALR = 32'h03E0_F809;
    localparam logic [31:0] I_SYSC = 32'h0000_000C;
    localparam logic [31:0] I_ERET = 32'h4200_0018;
    localparam logic [31:0] I_ADD  = 32'h0000_0020;

    always #5 clk = ~clk;

    pc_ctrl #(
        .WIDTH     (32),
        .RESET_PC  (32'h0000_3000),
        .EXC_VEC   (32'h0000_4180),
        .RAS_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_i     (stall),
        .branch_i    (branch),
        .jump_i      (jump),
        .ins_i       (ins),
        .jreg_i      (jreg),
        .irq_i       (irq),
        .pc_o        (pc),
        .link_addr_o (link_addr),
        .epc_o       (epc),
        .exl_o       (exl),
        .redirect_o  (redirect),
        .ras_pred_o  (ras_pred),
        .ras_valid_o (ras_valid)
    );

    function automatic obs_t sample();
        obs_t o;
        o.pc = pc; o.link = link_addr; o.epc = epc; o.pred = ras_pred;
        o.exl = exl; o.redir = redirect; o.valid = ras_valid;
        return o;
    endfunction

    function automatic string show(obs_t o);
        return $sformatf("pc=%h link=%h epc=%h exl=%b redir=%b ras_v=%b ras_p=%h",
                         o.pc, o.link, o.epc, o.exl, o.redir, o.valid, o.pred);
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.pc = m_pc; o.link = m_pc + 32'd8; o.epc = m_epc; o.exl = m_exl;
        o.redir = m_redir; o.valid = (m_ras.size() != 0);
        o.pred = (m_ras.size() != 0) ? m_ras[m_ras.size()-1] : 32'h0;
        return o;
    endfunction

    task automatic model_reset();
        m_pc = 32'h3000; m_epc = '0; m_exl = 1'b0; m_redir = 1'b0;
        m_ras.delete();
    endtask

    task automatic ras_push(input logic [31:0] v);
        m_ras.push_back(v);
        if (m_ras.size() > 4) m_ras.delete(0);
    endtask

    // Drive one cycle, advance the model, queue the expected post-edge state
    task automatic drive(input logic st, input logic br, input logic jp,
                         input logic [31:0] in, input logic [31:0] jr, input logic iq);
        logic [5:0]  op, fn;
        logic [4:0]  rs;
        logic [31:0] off;
        stall = st; branch = br; jump = jp; ins = in; jreg = jr; irq = iq;
        op = in[31:26]; fn = in[5:0]; rs = in[25:21];
        off = {{14{in[15]}}, in[15:0], 2'b00};
        if (!st) begin
            m_redir = 1'b1;
            if ((iq && !m_exl) || (jp && op == 6'd0 && fn == 6'd12)) begin
                m_epc = m_pc; m_exl = 1'b1; m_pc = 32'h4180;
            end else if (jp && op == 6'h10) begin
                m_pc = m_epc; m_exl = 1'b0;
            end else if (br) begin
                m_pc = m_pc + 32'd4 + off;
            end else if (jp && (op == 6'd2 || op == 6'd3)) begin
                if (op == 6'd3) ras_push(m_pc + 32'd8);
                m_pc = {m_pc[31:28], in[25:0], 2'b00};
            end else if (jp && op == 6'd0 && fn == 6'd8) begin
                if (rs == 5'd31 && m_ras.size() != 0) m_ras.delete(m_ras.size()-1);
                m_pc = jr;
            end else if (jp && op == 6'd0 && fn == 6'd9) begin
                ras_push(m_pc + 32'd8);
                m_pc = jr;
            end else begin
                m_pc = m_pc + 32'd4;
                m_redir = 1'b0;
            end
        end
        sb.push_back(model_obs());
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        stall = 0; branch = 0; jump = 0; ins = '0; jreg = '0; irq = 0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        obs_t got, exp;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        exp = '{pc: 32'h3000, link: 32'h3008, epc: 32'h0, pred: 32'h0,
                exl: 1'b0, redir: 1'b0, valid: 1'b0};
        got = sample();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset: got %s want %s", show(got), show(exp));
        end
        rst_n = 1'b1;
    endtask

    task automatic test_seq();
        obs_t got, exp;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, I_NOP, '0, 0);
            exp = sb.pop_front();
            got = sample();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL seq[%0d]: got %s want %s", i, show(got), show(exp));
            end
            checks++;
            if (pc !== 32'h3004 + 32'(i) * 32'd4 || redirect !== 1'b0) begin
                errors++;
                $display("FAIL seq_pc[%0d]: got pc=%h redir=%b want pc=%h redir=0",
                         i, pc, redirect, 32'h3004 + 32'(i) * 32'd4);
            end
        end
    endtask

    task automatic test_branch();
        obs_t got, exp;
        drive(0, 0, 0, I_NOP, '0, 0);
        drive(0, 1, 0, 32'h1000_FFFE, '0, 0);
        drive(0, 0, 0, I_NOP, '0, 0);
        for (int i = 0; i < 3; i++) begin
            exp = sb.pop_front();
            if (i == 2) begin
                checks++;
                if (redirect !== 1'b0 || pc !== 32'h3010) begin
                    errors++;
                    $display("FAIL branch_after: got pc=%h redir=%b want pc=00003010 redir=0",
                             pc, redirect);
                end
            end
            got = sample();
            if (i < 2) continue;
        end
        // re-run a fresh branch to check the redirect cycle itself
        drive(0, 1, 0, 32'h1000_FFFE, '0, 0);
        exp = sb.pop_front();
        got = sample();
        checks++;
        if (got !== exp || pc !== 32'h300C || redirect !== 1'b1) begin
            errors++;
            $display("FAIL branch: got %s want %s", show(got), show(exp));
        end
        drive(0, 0, 0, I_NOP, '0, 0);
        exp = sb.pop_front();
        got = sample();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL branch_drop: got %s want %s", show(got), show(exp));
        end
    endtask

    task automatic test_jal_jr();
        obs_t got, exp;
        apply_reset();
        checks++;
        if (link_addr !== 32'h3008) begin
            errors++;
            $display("FAIL link_addr: got %h want 00003008", link_addr);
        end
        drive(0, 0, 1, 32'h0C00_0C10, '0, 0);
        exp = sb.pop_front();
        got = sample();
        checks++;
        if (got !== exp || pc !== 32'h3040 || ras_pred !== 32'h3008 || ras_valid !== 1'b1) begin
            errors++;
            $display("FAIL jal: got %s want %s", show(got), show(exp));
        end
        drive(0, 0, 1, I_JR31, 32'h3008, 0);
        exp = sb.pop_front();
        got = sample();
        checks++;
        if (got !== exp || pc !== 32'h3008 || ras_valid !== 1'b0) begin
            errors++;
            $display("FAIL jr31: got %s want %s", show(got), show(exp));
        end
        drive(0, 0, 1, I_JALR, 32'h5000, 0);
        exp = sb.pop_front();
        got = sample();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL jalr: got %s want %s", show(got), show(exp));
        end
    endtask

    task automatic test_ras_overflow();
        obs_t got, exp;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 32'h0C00_0000 | (32'h0C00 + 32'(i + 1) * 32'h40), '0, 0);
            exp = sb.pop_front();
            got = sample();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL ras_push[%0d]: got %s want %s", i, show(got), show(exp));
            end
        end
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                checks++;
                if (ras_valid !== 1'b1 || ras_pred !== 32'h3408 - 32'(i) * 32'h100) begin
                    errors++;
                    $display("FAIL ras_top[%0d]: got v=%b p=%h want v=1 p=%h",
                             i, ras_valid, ras_pred, 32'h3408 - 32'(i) * 32'h100);
                end
            end
            drive(0, 0, 1, I_JR31, 32'h6000 + 32'(i) * 32'd4, 0);
            exp = sb.pop_front();
            got = sample();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL ras_pop[%0d]: got %s want %s", i, show(got), show(exp));
            end
        end
        checks++;
        if (ras_valid !== 1'b0 || pc !== 32'h6010) begin
            errors++;
            $display("FAIL ras_empty: got v=%b pc=%h want v=0 pc=00006010", ras_valid, pc);
        end
    endtask

    task automatic test_priority();
        obs_t got, exp;
        apply_reset();
        drive(0, 1, 1, 32'h0C00_0C10, '0, 0);
        drive(0, 0, 1, I_ADD, '0, 0);
        drive(0, 1, 1, I_ERET, '0, 0);
        for (int i = 0; i < 3; i++) begin
            exp = sb.pop_front();
            if (i == 0) begin
                checks++;
                if (exp.pc !== 32'h3000 + 32'd4 + 32'h3040 || exp.valid !== 1'b0) begin
                    errors++;
                    $display("FAIL prio_model: got pc=%h want %h", exp.pc, 32'h6044);
                end
            end
        end
        got = sample();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL prio: got %s want %s", show(got), show(exp));
        end
        drive(0, 0, 1, I_ADD, '0, 0);
        exp = sb.pop_front();
        got = sample();
        checks++;
        if (got !== exp || redirect !== 1'b0) begin
            errors++;
            $display("FAIL unlisted_jump: got %s want %s", show(got), show(exp));
        end
    endtask

    task automatic test_irq();
        obs_t got, exp;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, I_NOP, '0, 0);
            void'(sb.pop_front());
        end
        checks++;
        if (pc !== 32'h3020) begin
            errors++;
            $display("FAIL irq_setup: got pc=%h want 00003020", pc);
        end
        drive(0, 0, 0, I_NOP, '0, 1);
        exp = sb.pop_front();
        got = sample();
        checks++;
        if (got !== exp || pc !== 32'h4180 || epc !== 32'h3020 || exl !== 1'b1) begin
            errors++;
            $display("FAIL irq_entry: got %s want %s", show(got), show(exp));
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, I_NOP, '0, 1);
            exp = sb.pop_front();
            got = sample();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL irq_masked[%0d]: got %s want %s", i, show(got), show(exp));
            end
        end
        drive(0, 0, 1, I_ERET, '0, 1);
        exp = sb.pop_front();
        got = sample();
        checks++;
        if (got !== exp || pc !== 32'h3020 || exl !== 1'b0) begin
            errors++;
            $display("FAIL eret: got %s want %s", show(got), show(exp));
        end
        drive(0, 0, 0, I_NOP, '0, 1);
        exp = sb.pop_front();
        got = sample();
        checks++;
        if (got !== exp || pc !== 32'h4180 || epc !== 32'h3020 || exl !== 1'b1) begin
            errors++;
            $display("FAIL irq_reentry: got %s want %s", show(got), show(exp));
        end
        drive(0, 0, 1, I_SYSC, '0, 0);
        exp = sb.pop_front();
        got = sample();
        checks++;
        if (got !== exp || epc !== 32'h4180) begin
            errors++;
            $display("FAIL nested_syscall: got %s want %s", show(got), show(exp));
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (exl !== 1'b0 || epc !== 32'h0 || pc !== 32'h3000) begin
            errors++;
            $display("FAIL async_reset: got pc=%h epc=%h exl=%b want pc=00003000 epc=0 exl=0",
                     pc, epc, exl);
        end
        apply_reset();
    endtask

    task automatic test_stall();
        obs_t got, exp;
        apply_reset();
        drive(0, 0, 0, I_NOP, '0, 0);
        drive(0, 0, 0, I_NOP, '0, 0);
        drive(0, 1, 0, 32'h1000_0004, '0, 0);
        for (int i = 0; i < 3; i++) void'(sb.pop_front());
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 1, 32'h0C00_0C10, '0, 1);
            exp = sb.pop_front();
            got = sample();
            checks++;
            if (got !== exp || pc !== 32'h301C || redirect !== 1'b1 || exl !== 1'b0) begin
                errors++;
                $display("FAIL stall[%0d]: got %s want %s", i, show(got), show(exp));
            end
        end
        drive(0, 0, 1, 32'h0C00_0C10, '0, 1);
        exp = sb.pop_front();
        got = sample();
        checks++;
        if (got !== exp || pc !== 32'h4180 || epc !== 32'h301C || ras_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: got %s want %s", show(got), show(exp));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_seq();
        test_branch();
        test_jal_jr();
        test_ras_overflow();
        test_priority();
        test_irq();
        test_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
